// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_NUM_REGS   = 32;
   localparam int unsigned RF_AW         = $clog2(RF_NUM_REGS);
   localparam int unsigned RF_REG0       = 0;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_if.sv
// Read, write and issue ports of the register file with scoreboard.
interface regfile_scoreboard_if
   import regfile_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = RF_NUM_REGS
);
   localparam int unsigned AW = $clog2(NUM_REGS);

   logic [AW-1:0]         rsNum;
   logic [AW-1:0]         rtNum;
   logic [DATA_WIDTH-1:0] rsData;
   logic [DATA_WIDTH-1:0] rtData;
   logic [AW-1:0]         rdNum;
   logic [DATA_WIDTH-1:0] rdData;
   logic                  rdWriteEnable;
   logic [AW-1:0]         issueNum;
   logic                  issueValid;
   logic                  rsPending;
   logic                  rtPending;

   modport master (
      output rsNum, rtNum, rdNum, rdData, rdWriteEnable, issueNum, issueValid,
      input  rsData, rtData, rsPending, rtPending
   );

   modport slave (
      input  rsNum, rtNum, rdNum, rdData, rdWriteEnable, issueNum, issueValid,
      output rsData, rtData, rsPending, rtPending
   );

endinterface : regfile_scoreboard_if

// File: rtl/regfile_entry.sv
// One architectural register: enabled flop with synchronous reset.
module regfile_entry #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : regfile_entry

// File: rtl/regfile_scoreboard.sv
// Register file with hardwired r0, optional write bypass and per-register pending scoreboard.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = RF_NUM_REGS,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                clk,
   input  logic                reset,
   regfile_scoreboard_if.slave bus
);

   localparam int unsigned   AW   = $clog2(NUM_REGS);
   localparam logic [AW-1:0] ZERO = AW'(RF_REG0);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
   logic                                wr_en;
   logic                                issue_en;
   logic [NUM_REGS-1:0]                 wr_mask;
   logic [NUM_REGS-1:0]                 issue_mask;
   logic [NUM_REGS-1:0]                 pending_q;
   logic [NUM_REGS-1:0]                 pending_d;
   logic [NUM_REGS-1:0]                 pending_vis;

   assign wr_en      = bus.rdWriteEnable && (bus.rdNum != ZERO);
   assign issue_en   = bus.issueValid && (bus.issueNum != ZERO);
   assign wr_mask    = wr_en    ? (NUM_REGS'(1) << bus.rdNum)    : '0;
   assign issue_mask = issue_en ? (NUM_REGS'(1) << bus.issueNum) : '0;

   assign regs[0] = '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      regfile_entry #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_entry (
         .clk_i (clk),
         .rst_i (reset),
         .en_i  (wr_mask[g]),
         .d_i   (bus.rdData),
         .q_o   (regs[g])
      );
   end

   // Issue is applied after the clear so a same-cycle issue of the written register wins.
   always_comb begin
      pending_d = pending_q;
      pending_d = pending_d & ~wr_mask;
      pending_d = pending_d | issue_mask;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // A write hides its own pending bit this cycle only if that register is not re-issued.
   assign pending_vis = (BYPASS != 0) ? (pending_q & ~(wr_mask & ~issue_mask)) : pending_q;

   always_comb begin
      bus.rsData = regs[bus.rsNum];
      bus.rtData = regs[bus.rtNum];
      if ((BYPASS != 0) && wr_en && (bus.rsNum == bus.rdNum)) begin
         bus.rsData = bus.rdData;
      end
      if ((BYPASS != 0) && wr_en && (bus.rtNum == bus.rdNum)) begin
         bus.rtData = bus.rdData;
      end
   end

   assign bus.rsPending = pending_vis[bus.rsNum];
   assign bus.rtPending = pending_vis[bus.rtNum];

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard, forwarding and non-forwarding builds.
module tb_regfile_scoreboard;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   regfile_scoreboard_if #(.DATA_WIDTH(32), .NUM_REGS(32)) bus_a ();
   regfile_scoreboard_if #(.DATA_WIDTH(32), .NUM_REGS(32)) bus_b ();

   regfile_scoreboard #(
      .DATA_WIDTH (32),
      .NUM_REGS   (32),
      .BYPASS     (1)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   regfile_scoreboard #(
      .DATA_WIDTH (32),
      .NUM_REGS   (32),
      .BYPASS     (0)
   ) u_dut_nb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus_a.rsNum = '0; bus_a.rtNum = '0; bus_a.rdNum = '0; bus_a.rdData = '0;
      bus_a.rdWriteEnable = 1'b0; bus_a.issueNum = '0; bus_a.issueValid = 1'b0;
      bus_b.rsNum = '0; bus_b.rtNum = '0; bus_b.rdNum = '0; bus_b.rdData = '0;
      bus_b.rdWriteEnable = 1'b0; bus_b.issueNum = '0; bus_b.issueValid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state of every register and pending bit
      for (int i = 0; i < 32; i++) begin
         bus_a.rsNum = 5'(i);
         bus_a.rtNum = 5'(31 - i);
         #1;
         check("reset_rsData", bus_a.rsData, 32'h0);
         check("reset_rtData", bus_a.rtData, 32'h0);
         check("reset_rsPending", {31'b0, bus_a.rsPending}, 32'h0);
         check("reset_rtPending", {31'b0, bus_a.rtPending}, 32'h0);
      end

      // write r5 then read on both ports
      @(negedge clk);
      bus_a.rdNum = 5'd5; bus_a.rdData = 32'hDEADBEEF; bus_a.rdWriteEnable = 1'b1;
      bus_a.rsNum = 5'd1; bus_a.rtNum = 5'd2;
      @(negedge clk);
      bus_a.rdWriteEnable = 1'b0;
      bus_a.rsNum = 5'd5; bus_a.rtNum = 5'd5;
      #1;
      check("r5_rsData", bus_a.rsData, 32'hDEADBEEF);
      check("r5_rtData", bus_a.rtData, 32'hDEADBEEF);

      // r0 discards writes and never becomes pending
      @(negedge clk);
      bus_a.rdNum = 5'd0; bus_a.rdData = 32'h12345678; bus_a.rdWriteEnable = 1'b1;
      bus_a.issueNum = 5'd0; bus_a.issueValid = 1'b1;
      bus_a.rsNum = 5'd0; bus_a.rtNum = 5'd0;
      #1;
      check("r0_no_bypass", bus_a.rsData, 32'h0);
      @(negedge clk);
      bus_a.rdWriteEnable = 1'b0; bus_a.issueValid = 1'b0;
      #1;
      check("r0_rsData", bus_a.rsData, 32'h0);
      check("r0_rsPending", {31'b0, bus_a.rsPending}, 32'h0);

      // same-cycle bypass versus no bypass
      @(negedge clk);
      bus_a.rdNum = 5'd7; bus_a.rdData = 32'hA5A5A5A5; bus_a.rdWriteEnable = 1'b1;
      bus_a.rsNum = 5'd7; bus_a.rtNum = 5'd5;
      bus_b.rdNum = 5'd7; bus_b.rdData = 32'hA5A5A5A5; bus_b.rdWriteEnable = 1'b1;
      bus_b.rsNum = 5'd7;
      #1;
      check("bypass_rsData", bus_a.rsData, 32'hA5A5A5A5);
      check("bypass_other_rtData", bus_a.rtData, 32'hDEADBEEF);
      check("nobypass_old_rsData", bus_b.rsData, 32'h0);
      @(negedge clk);
      bus_a.rdWriteEnable = 1'b0;
      bus_b.rdWriteEnable = 1'b0;
      #1;
      check("nobypass_after_edge", bus_b.rsData, 32'hA5A5A5A5);
      check("bypass_after_edge", bus_a.rsData, 32'hA5A5A5A5);

      // scoreboard: issue r3 and r9
      @(negedge clk);
      bus_a.issueNum = 5'd3; bus_a.issueValid = 1'b1;
      @(negedge clk);
      bus_a.issueNum = 5'd9;
      @(negedge clk);
      bus_a.issueValid = 1'b0;
      bus_a.rsNum = 5'd3; bus_a.rtNum = 5'd9;
      #1;
      check("r3_pending", {31'b0, bus_a.rsPending}, 32'h1);
      check("r9_pending", {31'b0, bus_a.rtPending}, 32'h1);

      // write r3 clears; forwarded pending reads 0 in the same cycle
      @(negedge clk);
      bus_a.rdNum = 5'd3; bus_a.rdData = 32'h00000033; bus_a.rdWriteEnable = 1'b1;
      #1;
      check("r3_clear_fwd", {31'b0, bus_a.rsPending}, 32'h0);
      check("r9_untouched", {31'b0, bus_a.rtPending}, 32'h1);

      // issue and write r9 in the same cycle: set wins
      @(negedge clk);
      bus_a.rdNum = 5'd9; bus_a.rdData = 32'h00000099;
      bus_a.issueNum = 5'd9; bus_a.issueValid = 1'b1;
      bus_a.rsNum = 5'd9; bus_a.rtNum = 5'd3;
      #1;
      check("r9_reissue_fwd", {31'b0, bus_a.rsPending}, 32'h1);
      check("r3_cleared", {31'b0, bus_a.rtPending}, 32'h0);
      @(negedge clk);
      bus_a.rdWriteEnable = 1'b0; bus_a.issueValid = 1'b0;
      #1;
      check("r9_still_pending", {31'b0, bus_a.rsPending}, 32'h1);
      check("r3_not_pending", {31'b0, bus_a.rtPending}, 32'h0);
      check("r9_data", bus_a.rsData, 32'h00000099);
      check("r3_data", bus_a.rtData, 32'h00000033);

      // load r4, issue r4, then reset with a competing write and issue
      @(negedge clk);
      bus_a.rdNum = 5'd4; bus_a.rdData = 32'h00000055; bus_a.rdWriteEnable = 1'b1;
      @(negedge clk);
      bus_a.rdWriteEnable = 1'b0;
      bus_a.issueNum = 5'd4; bus_a.issueValid = 1'b1;
      @(negedge clk);
      bus_a.issueValid = 1'b0;
      bus_a.rsNum = 5'd4; bus_a.rtNum = 5'd5;
      #1;
      check("r4_loaded", bus_a.rsData, 32'h00000055);
      check("r4_pending", {31'b0, bus_a.rsPending}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      bus_a.rdNum = 5'd4; bus_a.rdData = 32'h00000066; bus_a.rdWriteEnable = 1'b1;
      bus_a.issueNum = 5'd4; bus_a.issueValid = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus_a.rdWriteEnable = 1'b0; bus_a.issueValid = 1'b0;
      #1;
      check("r4_after_reset", bus_a.rsData, 32'h0);
      check("r4_pending_after_reset", {31'b0, bus_a.rsPending}, 32'h0);
      check("r5_after_reset", bus_a.rtData, 32'h0);
      bus_a.rsNum = 5'd9;
      #1;
      check("r9_pending_after_reset", {31'b0, bus_a.rsPending}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile_scoreboard
